audio_ram_scheduler: RTL

//  Sequences the shared DDR RAM wrapper between the audio record path (ADC samples, s_end) and the

---
 rtl/audio_ram_scheduler.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/audio_ram_scheduler.sv
// rtl/audio_ram_scheduler.sv - record/playback sequencer for the shared audio DDR RAM
module audio_ram_scheduler #(
    parameter int ADDR_W  = 26,
    parameter int DATA_W  = 16,
    parameter int RD_TOUT = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        mode,
    input  logic              s_end,
    input  logic [DATA_W-1:0] audio_in,
    input  logic              s_req,
    output logic [DATA_W-1:0] audio_out,
    input  logic              ram_rdy,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data_in,
    output logic              ram_write_enable,
    output logic              ram_read_request,
    input  logic              ram_rd_data_pres,
    output logic              ram_read_ack,
    input  logic [DATA_W-1:0] ram_data_out,
    input  logic [ADDR_W-1:0] max_ram_address,
    output logic [ADDR_W-1:0] rec_len,
    output logic              overrun,
    output logic              underrun,
    output logic              busy
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WRITE  = 2'd1;
    localparam logic [1:0] S_RD_REQ = 2'd2;
    localparam logic [1:0] S_RD_ACK = 2'd3;
    localparam int         TW       = $clog2(RD_TOUT + 1);

    logic [1:0]        state;
    logic [2:0]        end_sync;
    logic [2:0]        req_sync;
    logic [1:0]        mode_q;
    logic              wr_pend;
    logic              rd_pend;
    logic              pf_valid;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [DATA_W-1:0] wr_buf;
    logic [DATA_W-1:0] prefetch;
    logic [TW-1:0]     tout_cnt;

    logic              end_evt;
    logic              req_evt;
    logic              tout_hit;
    logic              pf_fill;
    logic              rec_inc;
    logic              enter_rec;
    logic              enter_play;
    logic [ADDR_W:0]   rd_nxt;

    assign end_evt    = end_sync[1] & ~end_sync[2];
    assign req_evt    = req_sync[1] & ~req_sync[2];
    assign tout_hit   = (state == S_RD_REQ) && !ram_rd_data_pres && (tout_cnt == TW'(RD_TOUT - 1));
    // The prefetch slot is refilled this cycle; a simultaneous DAC request must not clear it.
    assign pf_fill    = (state == S_RD_REQ) && (ram_rd_data_pres || tout_hit);
    assign rec_inc    = (rec_len <= max_ram_address) && (rec_len != {ADDR_W{1'b1}});
    assign enter_rec  = (state == S_IDLE) && mode[0] && !mode_q[0];
    assign enter_play = (state == S_IDLE) && mode[1] && !mode_q[1];
    assign rd_nxt     = {1'b0, rd_ptr} + 1'b1;

    // RAM handshake outputs decode directly from the state so an async reset clears them at once.
    always_comb begin
        busy             = (state != S_IDLE);
        ram_write_enable = (state == S_WRITE);
        ram_read_request = (state == S_RD_REQ);
        ram_read_ack     = (state == S_RD_ACK);
        ram_data_in      = (state == S_WRITE) ? wr_buf : '0;
        ram_address      = '0;
        if (state == S_WRITE) begin
            ram_address = wr_ptr;
        end else if (state == S_RD_REQ || state == S_RD_ACK) begin
            ram_address = rd_ptr;
        end
    end

    // Bring the audio-domain strobes into clk with a 2-flop sync plus an edge-detect stage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            end_sync <= '0;
            req_sync <= '0;
        end else begin
            end_sync <= {end_sync[1:0], s_end};
            req_sync <= {req_sync[1:0], s_req};
        end
    end

    // RAM transaction FSM, mode application, sample buffering and prefetch bookkeeping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            mode_q    <= '0;
            wr_pend   <= 1'b0;
            rd_pend   <= 1'b0;
            pf_valid  <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            wr_buf    <= '0;
            prefetch  <= '0;
            tout_cnt  <= '0;
            rec_len   <= '0;
            audio_out <= '0;
            overrun   <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    tout_cnt <= '0;
                    if (ram_rdy && wr_pend) begin
                        state <= S_WRITE;
                    end else if (ram_rdy && rd_pend) begin
                        state <= S_RD_REQ;
                    end
                end
                S_WRITE: begin
                    wr_pend <= 1'b0;
                    wr_ptr  <= (wr_ptr == max_ram_address) ? '0 : wr_ptr + 1'b1;
                    if (rec_inc) begin
                        rec_len <= rec_len + 1'b1;
                    end
                    state <= S_IDLE;
                end
                S_RD_REQ: begin
                    if (ram_rd_data_pres) begin
                        prefetch <= ram_data_out;
                        pf_valid <= 1'b1;
                        state    <= S_RD_ACK;
                    end else if (tout_hit) begin
                        prefetch <= '0;
                        pf_valid <= 1'b1;
                        underrun <= 1'b1;
                        rd_pend  <= 1'b0;
                        state    <= S_IDLE;
                    end else begin
                        tout_cnt <= tout_cnt + 1'b1;
                    end
                end
                default: begin
                    rd_pend <= 1'b0;
                    rd_ptr  <= (rd_nxt >= {1'b0, rec_len}) ? '0 : rd_nxt[ADDR_W-1:0];
                    state   <= S_IDLE;
                end
            endcase

            if (state == S_IDLE) begin
                mode_q <= mode;
                if (enter_rec) begin
                    wr_ptr  <= '0;
                    rec_len <= '0;
                end
                if (enter_play) begin
                    rd_ptr   <= '0;
                    pf_valid <= 1'b0;
                    rd_pend  <= 1'b1;
                end
            end

            if (end_evt && mode_q[0]) begin
                wr_buf  <= audio_in;
                wr_pend <= 1'b1;
                // A buffer being written out this cycle is already consumed, so no loss.
                if (wr_pend && state != S_WRITE) begin
                    overrun <= 1'b1;
                end
            end

            if (!mode_q[1]) begin
                audio_out <= '0;
            end else if (req_evt) begin
                if (rec_len == '0) begin
                    audio_out <= '0;
                end else begin
                    audio_out <= pf_valid ? prefetch : '0;
                    if (!pf_valid) begin
                        underrun <= 1'b1;
                    end
                    if (!pf_fill) begin
                        pf_valid <= 1'b0;
                    end
                    rd_pend <= 1'b1;
                end
            end
        end
    end

endmodule
